// File: rtl/usart_tx.sv
// Serial transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// A one-entry holding buffer behind valid/ready lets the next byte queue during a frame.
module usart_tx #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BIT  = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BIT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W        = 3;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BIT - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [BIT_W-1:0]    bit_idx, bit_nx;
  logic [DATA_BIT-1:0] shift, shift_nx;
  logic [DATA_BIT-1:0] hold, hold_nx;
  logic                hold_full, hold_full_nx;
  logic                par_bit, par_nx;
  logic                tx_nx, busy_nx, done_nx, ready_nx;
  logic                bit_end;
  logic                load;

  // Only data[DATA_BIT-1:0] matters; the remaining bits are intentionally ignored.
  logic data_unused;
  assign data_unused = ^data;

  // State and datapath registers; outputs are registered from their next values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_nx;
      shift     <= shift_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      par_bit   <= par_nx;
      tx        <= tx_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      ready     <= ready_nx;
    end
  end

  // Next-state, buffer handshake and next output values.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bit_nx       = bit_idx;
    shift_nx     = shift;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    par_nx       = par_bit;
    load         = 1'b0;
    bit_end      = (cnt == CNT_LAST);

    if (valid && !hold_full) begin
      hold_nx      = data[DATA_BIT-1:0];
      hold_full_nx = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          cnt_nx   = '0;
          bit_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_nx = shift >> 1;
          cnt_nx   = '0;
          if (bit_idx == DATA_LAST) begin
            bit_nx   = '0;
            state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_nx = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nx = S_STOP;
          cnt_nx   = '0;
          bit_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (bit_idx == STOP_LAST) begin
            bit_nx = '0;
            // A queued byte starts its frame with no idle gap.
            if (hold_full) load = 1'b1;
            else           state_nx = S_IDLE;
          end else begin
            bit_nx = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        bit_nx   = '0;
      end
    endcase

    if (load) begin
      shift_nx     = hold;
      par_nx       = (^hold) ^ (PARITY == 1);
      hold_full_nx = 1'b0;
      state_nx     = S_START;
      cnt_nx       = '0;
      bit_nx       = '0;
    end

    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
      S_PARITY: tx_nx = par_nx;
      default:  tx_nx = 1'b1;
    endcase

    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state_nx == S_STOP) && (cnt_nx == CNT_LAST) && (bit_nx == STOP_LAST);
    ready_nx = !hold_full_nx;
  end

endmodule

// File: tb/tb_usart_tx.sv
// Scoreboard bench for usart_tx: three configurations (8N1, 7E2, 7O2) at 16 clocks per bit,
// each line decoded cycle-by-cycle by a monitor that pops hand-computed expected frames.
module tb_usart_tx;

  typedef struct packed {
    logic [7:0] val;
    logic       par;
    logic       gap0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_v [3];
  logic [2:0] valid_v;
  logic [2:0] ready_v, tx_v, busy_v, done_v;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(8), .PARITY(0), .STOP_BIT(1)) u_a (
    .clk(clk), .reset(reset), .data(data_v[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  usart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(7), .PARITY(2), .STOP_BIT(2)) u_e (
    .clk(clk), .reset(reset), .data(data_v[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  usart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(7), .PARITY(1), .STOP_BIT(2)) u_o (
    .clk(clk), .reset(reset), .data(data_v[2]), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  function automatic int cfg_db(input int k);
    return (k == 0) ? 8 : 7;
  endfunction

  function automatic int cfg_par(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int cfg_sb(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int k, output exp_t e, output bit ok);
    ok = 1'b1;
    e  = '0;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : ((k == 1) ? q1.size() : q2.size());
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input int k, input logic [7:0] val, input bit chk_lat);
    int n = 0;
    valid_v[k] = 1'b1;
    data_v[k]  = val;
    while (!ready_v[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[k]) begin
      chk("accept_timeout", 32'(n), 32'(0));
      valid_v[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    valid_v[k] = 1'b0;
    if (chk_lat) begin
      chk("latency_idle_cycle", 32'(tx_v[k]), 32'(1));
      @(negedge clk);
      chk("latency_start_fall", 32'(tx_v[k]), 32'(0));
    end
  endtask

  task automatic drain(input int k);
    int n = 0;
    while ((qsize(k) != 0 || busy_v[k]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= 3000), 32'(0));
  endtask

  // Decodes one line: every cycle of every bit must hold its level, busy stays high,
  // and done is high only in the final cycle of the last stop bit.
  task automatic monitor(input int k);
    int db, pb, sb, nb, start_c, last_end;
    logic [11:0] lv, ev;
    bit abort, bad_t, bad_d, ok;
    exp_t e;
    db = cfg_db(k);
    pb = cfg_par(k);
    sb = cfg_sb(k);
    nb = 1 + db + ((pb != 0) ? 1 : 0) + sb;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (!(reset === 1'b0 && tx_v[k] === 1'b0)) continue;
      start_c = cyc;
      abort = 1'b0;
      bad_t = 1'b0;
      bad_d = 1'b0;
      lv = '0;
      for (int b = 0; b < nb && !abort; b++) begin
        for (int c = 0; c < 16 && !abort; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset) begin
            abort = 1'b1;
          end else begin
            if (c == 0) lv[b] = tx_v[k];
            else if (tx_v[k] !== lv[b]) bad_t = 1'b1;
            if (busy_v[k] !== 1'b1) bad_t = 1'b1;
            if (done_v[k] !== ((b == nb - 1 && c == 15) ? 1'b1 : 1'b0)) bad_d = 1'b1;
          end
        end
      end
      if (abort) begin
        while (reset) @(negedge clk);
        continue;
      end
      pop(k, e, ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame line=%0d actual=%03h required=none", k, lv);
      end else begin
        ev = '0;
        for (int i = 0; i < db; i++) ev[1 + i] = e.val[i];
        if (pb != 0) ev[1 + db] = e.par;
        for (int s = 0; s < sb; s++) ev[nb - sb + s] = 1'b1;
        chk($sformatf("frame_bits_line%0d", k), 32'(lv), 32'(ev));
        chk($sformatf("bit_timing_line%0d", k), 32'(bad_t), 32'(0));
        chk($sformatf("done_pulse_line%0d", k), 32'(bad_d), 32'(0));
        if (e.gap0) chk($sformatf("zero_gap_line%0d", k), 32'(start_c - last_end), 32'(1));
      end
      last_end = cyc;
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit flag;
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

    #2 reset = 1'b1;
    #1;
    chk("reset_tx", 32'(tx_v), 32'(3'b111));
    chk("reset_ready", 32'(ready_v), 32'(3'b111));
    chk("reset_busy", 32'(busy_v), 32'(3'b000));
    chk("reset_done", 32'(done_v), 32'(3'b000));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0x55: alternating levels, one idle cycle after accept.
    push(0, exp_t'{8'h55, 1'b0, 1'b0});
    send(0, 8'h55, 1'b1);
    drain(0);
    chk("idle_after_frame_tx", 32'(tx_v[0]), 32'(1));

    // Back-to-back: second byte queued during the first frame's data phase.
    push(0, exp_t'{8'hA3, 1'b0, 1'b0});
    push(0, exp_t'{8'h0F, 1'b0, 1'b1});
    send(0, 8'hA3, 1'b0);
    repeat (40) @(negedge clk);
    send(0, 8'h0F, 1'b0);
    flag = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ready_v[0] !== 1'b0) flag = 1'b1;
      @(negedge clk);
    end
    chk("ready_held_low_while_buffered", 32'(flag), 32'(0));
    drain(0);

    // 7E2 and 7O2 of 0x07; bit 7 of the second byte must be ignored.
    push(1, exp_t'{8'h07, 1'b1, 1'b0});
    push(2, exp_t'{8'h07, 1'b0, 1'b0});
    send(1, 8'h07, 1'b1);
    send(2, 8'h87, 1'b0);
    drain(1);
    drain(2);

    // Handshake hold-off: junk offered while ready is low must never be sent.
    push(0, exp_t'{8'h11, 1'b0, 1'b0});
    push(0, exp_t'{8'h22, 1'b0, 1'b1});
    push(0, exp_t'{8'hC6, 1'b0, 1'b1});
    send(0, 8'h11, 1'b0);
    repeat (20) @(negedge clk);
    send(0, 8'h22, 1'b0);
    flag = 1'b0;
    valid_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_v[0] = 8'h30 + 8'(i);
      if (ready_v[0] !== 1'b0) flag = 1'b1;
      @(negedge clk);
    end
    chk("holdoff_ready_low", 32'(flag), 32'(0));
    send(0, 8'hC6, 1'b0);
    drain(0);

    // Reset during data bit 3 with a byte buffered: both are discarded.
    send(0, 8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    send(0, 8'hE1, 1'b0);
    repeat (50) @(negedge clk);
    chk("pre_reset_busy", 32'(busy_v[0]), 32'(1));
    chk("pre_reset_ready", 32'(ready_v[0]), 32'(0));
    #3 reset = 1'b1;
    #1;
    chk("midframe_reset_tx", 32'(tx_v[0]), 32'(1));
    chk("midframe_reset_ready", 32'(ready_v[0]), 32'(1));
    chk("midframe_reset_busy", 32'(busy_v[0]), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) flag = 1'b1;
    end
    chk("no_residual_frame", 32'(flag), 32'(0));

    // Loopback-style byte stream.
    push(0, exp_t'{8'h00, 1'b0, 1'b0});
    push(0, exp_t'{8'hFF, 1'b0, 1'b1});
    push(0, exp_t'{8'h80, 1'b0, 1'b1});
    push(0, exp_t'{8'h01, 1'b0, 1'b1});
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b0);
    send(0, 8'h80, 1'b0);
    send(0, 8'h01, 1'b0);
    drain(0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usart_tx.md
Name: usart_tx

Overview:
UART/USART serial transmitter that serializes parallel bytes onto a single `tx` line. Frame format is start bit, LSB-first data, optional parity, then stop bit(s). It is the transmit-side counterpart of the team's USART receiver and uses the same CLK_FREQ/BAUD_RATE bit-timing model. It has a one-entry holding buffer behind a valid/ready handshake, so the next byte can be queued while the current frame shifts out.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be ≥ 2).
- DATA_BIT, 8, data bits per frame. Legal values are 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BIT, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  8  byte to send. Only bits [DATA_BIT-1:0] are used; upper bits are ignored.
- valid  input  1  data is presented this cycle.
- ready  output  1  holding buffer is empty; a transfer occurs on a rising edge where valid && ready.
- tx  output  1  serial line, registered. Idle level is 1.
- busy  output  1  high while a frame is on the line (any state other than IDLE).
- done  output  1  one-cycle pulse in the last cycle of the final stop bit of each frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, ready=1, busy=0, done=0.
  - Holding buffer cleared; FSM goes to IDLE; bit and clock counters cleared.
- Reset mid-frame: tx returns to 1 immediately. The partial frame is abandoned and any buffered byte is discarded. After reset is released, no residual bits are sent.
- Holding buffer:
  - ready = ~hold_full, driven directly from a register.
  - On a valid && ready edge: capture data[DATA_BIT-1:0] and set hold_full.
  - While ready=0, data/valid are ignored. The master must hold valid and data until the transfer occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If hold_full, then at the next edge: move hold into the shift register, clear hold_full, enter START.
  - START: tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After DATA_BIT bits, go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY: tx = XOR of the DATA_BIT data bits (even), or its inverse (odd), for CLKS_PER_BIT cycles. Then go to STOP.
  - STOP: tx=1 for STOP_BIT×CLKS_PER_BIT cycles. In the last cycle, done=1. Then:
    - if hold_full, go directly to START (back-to-back frames, zero idle cycles);
    - otherwise go to IDLE.
- Latency: with the FSM in IDLE and the buffer empty, a byte accepted at edge N sets hold_full at N. tx falls at edge N+1.
- Frame length in cycles is exactly CLKS_PER_BIT × (1 + DATA_BIT + (PARITY≠0) + STOP_BIT), with no jitter.
- Simultaneous events:
  - A drain from hold into the shift register frees the buffer at that edge, so ready=1 in the following cycle.
  - An accept and a drain cannot occur on the same edge, because ready=0 whenever hold_full=1.
- Clock counter: width is $clog2(CLKS_PER_BIT)+1. It resets to 0 on every bit boundary and never wraps mid-bit.
- tx is glitch-free (registered), and its value only changes on bit boundaries.

Test Plan:
- Sim params CLK_FREQ=16, BAUD_RATE=1 (16 clocks/bit), 8N1. Send 0x55 → tx stays 1 for 1 cycle after accept, then shows 0,1,0,1,0,1,0,1,0,1 with each level lasting 16 cycles. done pulses once, exactly 160 cycles after tx falls. busy is high for those 160 cycles.
- Back-to-back: offer 0xA3, then offer 0x0F while the first frame is in DATA. Required response:
  - ready drops for the second byte until the first byte drains;
  - the second start bit begins the cycle after the first frame's final stop cycle (zero gap);
  - the decoded bytes are 0xA3, 0x0F.
- PARITY=2, DATA_BIT=7, STOP_BIT=2, send 0x07:
  - data bits 1,1,1,0,0,0,0, then parity bit 1, then stop high for 32 cycles;
  - total frame 176 cycles.
  - Repeat with PARITY=1 → parity bit 0.
- Reset mid-frame: assert reset during data bit 3 with a byte also buffered. Required response:
  - tx=1 immediately, ready=1, busy=0;
  - after release, the line stays 1 for ≥ 200 cycles with no frame.
- Handshake hold-off: keep valid=1 with changing data while ready=0. Only the value present at the accepting edge is transmitted; the earlier values are never sent.
- Loopback of bytes 0x00, 0xFF, 0x80, 0x01 into the USART receiver at identical CLK_FREQ/BAUD_RATE (8N1) → receiver reports all four bytes, in order, unchanged.
